// File: rtl/bw_seq_mult_7x5.sv
// Sequential signed Baugh-Wooley multiplier: A_W x B_W -> A_W+B_W two's-complement product.
// Latency: product visible (out_valid) 5 edges after the accepting edge; one product per 7 cycles.
// Backpressure: DONE holds p/out_valid indefinitely while out_ready=0; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b sampled on in_valid & in_ready)
//   a, b                  signed multiplicand / multiplier
//   out_valid/out_ready   result handshake, p stable while out_valid is high
//   p                     signed product
//   busy                  high whenever a product is in flight or waiting (RUN or DONE)
module bw_seq_mult_7x5 #(
    parameter int A_W = 7,
    parameter int B_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] p,
    output logic               busy
);

    localparam int P_W = A_W + B_W;
    localparam int JW  = $clog2(B_W);
    localparam logic [JW-1:0] J_LAST = JW'(B_W - 1);
    // Baugh-Wooley correction constant: the inverted sign-row/sign-column cells
    // are compensated by pre-loading the accumulator with these three powers of two.
    localparam logic [P_W-1:0] ACC_INIT =
        P_W'((1 << (A_W - 1)) + (1 << (B_W - 1)) + (1 << (P_W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    logic [P_W-1:0] acc;
    logic [JW-1:0]  j;

    logic [A_W-1:0] row;
    logic [P_W-1:0] row_ext;
    logic [P_W-1:0] acc_sum;
    logic           accept;
    logic           last_row;
    logic           j_bad;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;
    assign last_row  = (j == J_LAST);
    assign j_bad     = (j > J_LAST);

    // Row j of the cell array. The sign column (i = A_W-1) is inverted on every row
    // except the sign row; the sign row is inverted everywhere except the sign column,
    // so the sign-by-sign cell ends up uninverted.
    always_comb begin
        row = '0;
        for (int i = 0; i < A_W; i++) begin
            row[i] = (ra[i] & rb[j]) ^ ((i == A_W - 1) ^ last_row);
        end
    end

    assign row_ext = P_W'(row) << j;
    assign acc_sum = acc + row_ext;   // modulo 2^P_W, carry out discarded

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (j_bad) begin
                    state_nxt = IDLE;
                end else if (last_row) begin
                    state_nxt = DONE;
                end
            end
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra  <= '0;
            rb  <= '0;
            acc <= '0;
            j   <= '0;
            p   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ra  <= a;
                        rb  <= b;
                        acc <= ACC_INIT;
                        j   <= '0;
                    end
                end
                RUN: begin
                    if (!j_bad) begin
                        acc <= acc_sum;
                        if (last_row) begin
                            p <= acc_sum;
                            j <= '0;
                        end else begin
                            j <= j + JW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_seq_mult_7x5.sv
// Self-checking bench for bw_seq_mult_7x5: directed corner products, handshake timing,
// backpressure, back-to-back operation, asynchronous reset abort and all 128x32 operand pairs.
// Expected products come from plain signed integer multiplication.
module tb_bw_seq_mult_7x5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  a;
    logic [4:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] p;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bw_seq_mult_7x5 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_prod(input logic [6:0] av, input logic [4:0] bv);
        int sa;
        int sb;
        sa = $signed(av);
        sb = $signed(bv);
        return 12'(sa * sb);
    endfunction

    // Drives one operation from a quiet IDLE sync point (posedge+1) and returns what was seen.
    // Ends at the sync point after the result handshake edge.
    task automatic run_op(input logic [6:0] av, input logic [4:0] bv, input int gap, input int hold,
                          output logic [11:0] pv, output int lat, output bit got, output bit bad);
        int n;
        bad = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        a = av;
        b = bv;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 7'($urandom);
        b = 5'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        got = (out_valid === 1'b1);
        pv = p;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs in_ready=%b out_valid=%b busy=%b p=%h exp 1 0 0 000",
                     in_ready, out_valid, busy, p);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b busy=%b exp 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed;
        logic [6:0]  da [5] = '{7'h3F, 7'h40, 7'h40, 7'h7F, 7'h00};
        logic [4:0]  db [5] = '{5'h0F, 5'h10, 5'h0F, 5'h1F, 5'h13};
        logic [11:0] dp [5] = '{12'h3B1, 12'h400, 12'hC40, 12'h001, 12'h000};
        logic [11:0] pv;
        int lat;
        bit got;
        bit bad;
        for (int i = 0; i < 5; i++) begin
            run_op(da[i], db[i], 0, 0, pv, lat, got, bad);
            checks++;
            if (pv !== dp[i]) begin
                failures++;
                $display("FAIL dir_product[%0d] p=%h exp=%h", i, pv, dp[i]);
            end
            checks++;
            if (!got || lat != 5) begin
                failures++;
                $display("FAIL dir_latency[%0d] got_valid=%b edges=%0d exp 1 5", i, got, lat);
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL dir_busy[%0d] busy/in_ready wrong while in flight, exp busy=1 in_ready=0", i);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [6:0]  av;
        logic [4:0]  bv;
        logic [11:0] exp_p;
        int n;
        av = 7'($urandom);
        bv = 5'($urandom);
        exp_p = ref_prod(av, bv);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 10; c++) begin
            a = 7'($urandom);
            b = 5'($urandom);
            checks++;
            if (out_valid !== 1'b1 || p !== exp_p || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] out_valid=%b p=%h in_ready=%b exp 1 %h 0",
                         c, out_valid, p, in_ready, exp_p);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0]  pa [3];
        logic [4:0]  pb [3];
        logic [11:0] expq [$];
        logic [11:0] e;
        int idx = 0;
        int nres = 0;
        int last_t = -1;
        int cyc = 0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 7'($urandom);
            pb[i] = 5'($urandom);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (nres < 3 && cyc < 100) begin
            if (out_valid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : 12'hxxx;
                checks++;
                if (p !== e) begin
                    failures++;
                    $display("FAIL b2b_product[%0d] p=%h exp=%h", nres, p, e);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (cyc - last_t != 7) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d] cycles=%0d exp=7", nres, cyc - last_t);
                    end
                end
                last_t = cyc;
                nres++;
            end
            if (in_ready === 1'b1) begin
                if (idx < 3) begin
                    a = pa[idx];
                    b = pb[idx];
                    expq.push_back(ref_prod(pa[idx], pb[idx]));
                    idx++;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                a = 7'($urandom);
                b = 5'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres != 3) begin
            failures++;
            $display("FAIL b2b_count results=%0d exp=3", nres);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        logic [11:0] pv;
        int lat;
        bit got;
        bit bad;
        bit seen;
        run_op(7'h3F, 5'h0F, 0, 0, pv, lat, got, bad);
        in_valid = 1'b1;
        a = 7'h25;
        b = 5'h0B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 12'h000) begin
            failures++;
            $display("FAIL arst_immediate in_ready=%b out_valid=%b busy=%b p=%h exp 1 0 0 000",
                     in_ready, out_valid, busy, p);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL arst_no_result out_valid/busy seen=%b exp=0", seen);
        end
        run_op(7'h5A, 5'h17, 0, 0, pv, lat, got, bad);
        checks++;
        if (pv !== ref_prod(7'h5A, 5'h17) || !got) begin
            failures++;
            $display("FAIL arst_next_op p=%h valid=%b exp=%h 1", pv, got, ref_prod(7'h5A, 5'h17));
        end
    endtask

    task automatic test_exhaustive;
        logic [11:0] pv;
        logic [11:0] e;
        int lat;
        bit got;
        bit bad;
        for (int ai = 0; ai < 128; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
                run_op(7'(ai), 5'(bi), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       pv, lat, got, bad);
                e = ref_prod(7'(ai), 5'(bi));
                checks++;
                if (pv !== e || !got || lat != 5) begin
                    failures++;
                    $display("FAIL exh a=%h b=%h p=%h valid=%b lat=%0d exp p=%h valid=1 lat=5",
                             7'(ai), 5'(bi), pv, got, lat, e);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        test_reset;
        test_directed;
        test_backpressure;
        test_back_to_back;
        test_async_reset;
        test_exhaustive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
